// File: rtl/cpu_bus_pkg.sv
// Shared types and register map for the CPU bus responder.
// Used by cpu_bus_table and cpu_bus_responder.
package cpu_bus_pkg;

    typedef enum logic [1:0] {
        BANK_REG   = 2'd0,
        BANK_CYCLE = 2'd1,
        BANK_DUTY  = 2'd2,
        BANK_PHASE = 2'd3
    } bank_t;

    localparam logic [7:0] REG_CTRL   = 8'h00;
    localparam logic [7:0] REG_STATUS = 8'h01;
    localparam logic [7:0] REG_STEP   = 8'h02;

    localparam int CTRL_COMMIT    = 0;
    localparam int CTRL_FORCE_FAN = 1;
    localparam int CTRL_CLR_OVR   = 2;

    localparam int STATUS_BUSY    = 0;
    localparam int STATUS_OVERRUN = 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        STREAM = 2'd2
    } stream_state_t;

endpackage

// File: rtl/cpu_bus_table.sv
// Shadow cycle/duty/phase tables: CPU write port plus one
// registered read port shared by the streamer and CPU readback.
module cpu_bus_table
    import cpu_bus_pkg::*;
#(
    parameter int WIDTH     = 13,
    parameter int TRANS_NUM = 249
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  bank_t            wr_bank,
    input  logic [7:0]       wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [7:0]       rd_addr,
    output logic [WIDTH-1:0] rd_cycle,
    output logic [WIDTH-1:0] rd_duty,
    output logic [WIDTH-1:0] rd_phase
);

    logic [WIDTH-1:0] mem_cycle [TRANS_NUM];
    logic [WIDTH-1:0] mem_duty  [TRANS_NUM];
    logic [WIDTH-1:0] mem_phase [TRANS_NUM];

    // CPU write port; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            unique case (wr_bank)
                BANK_CYCLE: mem_cycle[wr_addr] <= wr_data;
                BANK_DUTY:  mem_duty[wr_addr]  <= wr_data;
                BANK_PHASE: mem_phase[wr_addr] <= wr_data;
                default: ;
            endcase
        end
    end

    // Read port; data holds whenever no read is enabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_cycle <= '0;
            rd_duty  <= '0;
            rd_phase <= '0;
        end else if (rd_en) begin
            rd_cycle <= mem_cycle[rd_addr];
            rd_duty  <= mem_duty[rd_addr];
            rd_phase <= mem_phase[rd_addr];
        end
    end

endmodule

// File: rtl/cpu_bus_responder.sv
// CPU bus responder: register/table decode, read tri-state and
// commit streamer. Optional table readback: AUTD_CPU_READBACK_EN.
module cpu_bus_responder
    import cpu_bus_pkg::*;
#(
    parameter int          WIDTH     = 13,
    parameter int          TRANS_NUM = 249,
    parameter logic [15:0] VERSION   = 16'h0002
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic [15:0]      CPU_ADDR,
    inout  wire  [15:0]      CPU_DATA,
    input  logic             CPU_CS_N,
    input  logic             CPU_WE_N,
    input  logic             CPU_RD_N,
    output logic [WIDTH-1:0] STEP,
    output logic             FORCE_FAN,
    output logic             BUSY,
    output logic [7:0]       OUT_IDX,
    output logic [WIDTH-1:0] OUT_CYCLE,
    output logic [WIDTH-1:0] OUT_DUTY,
    output logic [WIDTH-1:0] OUT_PHASE,
    output logic             OUT_VALID,
    input  logic             OUT_READY
);

    // Table depth must fit the 8-bit offset field
    localparam logic [7:0] DEPTH    = 8'(TRANS_NUM);
    localparam logic [7:0] LAST_IDX = 8'(TRANS_NUM - 1);

    stream_state_t state, state_nxt;

    bank_t            bank;
    logic [7:0]       off;
    logic [WIDTH-1:0] wdata;
    logic             we_n_q;
    logic             wr_evt;
    logic             ctrl_wr;
    logic             commit;
    logic             tbl_wr;
    logic             tbl_we;
    logic             start;
    logic             drop;
    logic             busy;
    logic             fetch;
    logic             valid;
    logic             overrun;
    logic             force_fan;
    logic [WIDTH-1:0] step;
    logic [7:0]       idx;
    logic             rd_req;
    logic             cpu_tbl_rd;
    logic             rd_act_q;
    logic [15:0]      reg_rdata;
    logic [15:0]      rd_reg_q;
    logic [15:0]      rd_data;
    logic [WIDTH-1:0] tbl_cycle;
    logic [WIDTH-1:0] tbl_duty;
    logic [WIDTH-1:0] tbl_phase;
    logic             unused_bits;

    assign bank  = bank_t'(CPU_ADDR[15:14]);
    assign off   = CPU_ADDR[7:0];
    assign wdata = CPU_DATA[WIDTH-1:0];

    assign unused_bits = ^{CPU_ADDR[13:8], CPU_DATA[15:WIDTH]};

    // A write fires once, on the first edge that sees WE_N low
    assign wr_evt  = !CPU_CS_N && !CPU_WE_N && we_n_q;
    assign ctrl_wr = wr_evt && bank == BANK_REG && off == REG_CTRL;
    assign commit  = ctrl_wr && CPU_DATA[CTRL_COMMIT];
    assign tbl_wr  = wr_evt && bank != BANK_REG;
    assign start   = commit && !busy;
    assign drop    = busy && (commit || tbl_wr);
    assign tbl_we  = tbl_wr && !busy && off < DEPTH;

    // A pending write blocks the read driver
    assign rd_req = !CPU_CS_N && !CPU_RD_N && CPU_WE_N;

    // WE_N history for single-shot write detection
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            we_n_q <= 1'b1;
        end else begin
            we_n_q <= CPU_WE_N;
        end
    end

    // Control registers; a dropped commit outranks a same-write clear
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            step      <= '0;
            force_fan <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (wr_evt && bank == BANK_REG && off == REG_STEP) begin
                step <= wdata;
            end
            if (ctrl_wr) begin
                force_fan <= CPU_DATA[CTRL_FORCE_FAN];
            end
            if (drop) begin
                overrun <= 1'b1;
            end else if (ctrl_wr && CPU_DATA[CTRL_CLR_OVR]) begin
                overrun <= 1'b0;
            end
        end
    end

    // Streamer state register
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Streamer next state
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = FETCH;
            FETCH:   state_nxt = STREAM;
            STREAM: begin
                if (OUT_READY) begin
                    state_nxt = (idx == LAST_IDX) ? IDLE : FETCH;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Streamer outputs
    always_comb begin
        fetch = 1'b0;
        valid = 1'b0;
        busy  = 1'b1;
        unique case (state)
            IDLE:    busy  = 1'b0;
            FETCH:   fetch = 1'b1;
            STREAM:  valid = 1'b1;
            default: busy  = 1'b0;
        endcase
    end

    // Entry index: restarts on commit, advances on handshake
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            idx <= '0;
        end else if (start) begin
            idx <= '0;
        end else if (valid && OUT_READY && idx != LAST_IDX) begin
            idx <= idx + 8'd1;
        end
    end

`ifdef AUTD_CPU_READBACK_EN
    // CPU may use the read port only while the streamer is idle
    assign cpu_tbl_rd = rd_req && bank != BANK_REG
                        && off < DEPTH && state == IDLE;
`else
    assign cpu_tbl_rd = 1'b0;
`endif

    cpu_bus_table #(
        .WIDTH     (WIDTH),
        .TRANS_NUM (TRANS_NUM)
    ) u_table (
        .clk      (CLK),
        .rst_n    (RESET_N),
        .wr_en    (tbl_we),
        .wr_bank  (bank),
        .wr_addr  (off),
        .wr_data  (wdata),
        .rd_en    (fetch || cpu_tbl_rd),
        .rd_addr  (fetch ? idx : off),
        .rd_cycle (tbl_cycle),
        .rd_duty  (tbl_duty),
        .rd_phase (tbl_phase)
    );

    // Register-bank read mux; non-register banks read as zero here
    always_comb begin
        reg_rdata = '0;
        if (bank == BANK_REG) begin
            unique case (1'b1)
                (off == REG_CTRL): begin
                    reg_rdata[CTRL_FORCE_FAN] = force_fan;
                end
                (off == REG_STATUS): begin
                    reg_rdata[15:8]           = VERSION[7:0];
                    reg_rdata[STATUS_OVERRUN] = overrun;
                    reg_rdata[STATUS_BUSY]    = busy;
                end
                (off == REG_STEP): begin
                    reg_rdata = 16'(step);
                end
                default: ;
            endcase
        end
    end

    // Read path: one-cycle latency, drive lingers one cycle
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            rd_act_q <= 1'b0;
            rd_reg_q <= '0;
        end else begin
            rd_act_q <= rd_req;
            rd_reg_q <= reg_rdata;
        end
    end

`ifdef AUTD_CPU_READBACK_EN
    logic        rd_tbl_q;
    bank_t       rd_bank_q;
    logic [15:0] tbl_rdata;

    // Remember which table the CPU read port was serving
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            rd_tbl_q  <= 1'b0;
            rd_bank_q <= BANK_REG;
        end else begin
            rd_tbl_q  <= cpu_tbl_rd;
            rd_bank_q <= bank;
        end
    end

    // Select the table word for the bus
    always_comb begin
        tbl_rdata = '0;
        unique case (rd_bank_q)
            BANK_CYCLE: tbl_rdata = 16'(tbl_cycle);
            BANK_DUTY:  tbl_rdata = 16'(tbl_duty);
            BANK_PHASE: tbl_rdata = 16'(tbl_phase);
            default: ;
        endcase
    end

    assign rd_data = rd_tbl_q ? tbl_rdata : rd_reg_q;
`else
    assign rd_data = rd_reg_q;
`endif

    assign CPU_DATA = rd_act_q ? rd_data : 16'hzzzz;

    assign STEP      = step;
    assign FORCE_FAN = force_fan;
    assign BUSY      = busy;
    assign OUT_VALID = valid;
    assign OUT_IDX   = valid ? idx : 8'd0;
    assign OUT_CYCLE = valid ? tbl_cycle : '0;
    assign OUT_DUTY  = valid ? tbl_duty : '0;
    assign OUT_PHASE = valid ? tbl_phase : '0;

endmodule

// File: tb/tb_cpu_bus_responder.sv
// Self-checking bench for cpu_bus_responder: bus-level model of
// the register map, tables and commit stream, randomized traffic.
`timescale 1ns/1ps
module tb_cpu_bus_responder;

    localparam int WIDTH = 13;
    localparam int N     = 249;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [15:0]       addr = '0;
    logic              cs_n = 1'b1;
    logic              we_n = 1'b1;
    logic              rd_n = 1'b1;
    logic              tb_drv = 1'b0;
    logic [15:0]       tb_dat = '0;
    logic              out_ready = 1'b0;
    tri1  [15:0]       cpu_data;
    logic [WIDTH-1:0]  step_o;
    logic              force_fan_o;
    logic              busy_o;
    logic [7:0]        out_idx;
    logic [WIDTH-1:0]  out_cycle;
    logic [WIDTH-1:0]  out_duty;
    logic [WIDTH-1:0]  out_phase;
    logic              out_valid;

    assign cpu_data = tb_drv ? tb_dat : 16'hzzzz;

    cpu_bus_responder dut (
        .CLK       (clk),
        .RESET_N   (rst_n),
        .CPU_ADDR  (addr),
        .CPU_DATA  (cpu_data),
        .CPU_CS_N  (cs_n),
        .CPU_WE_N  (we_n),
        .CPU_RD_N  (rd_n),
        .STEP      (step_o),
        .FORCE_FAN (force_fan_o),
        .BUSY      (busy_o),
        .OUT_IDX   (out_idx),
        .OUT_CYCLE (out_cycle),
        .OUT_DUTY  (out_duty),
        .OUT_PHASE (out_phase),
        .OUT_VALID (out_valid),
        .OUT_READY (out_ready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [12:0] m_cyc  [N];
    logic [12:0] m_duty [N];
    logic [12:0] m_ph   [N];
    logic [12:0] m_step = '0;
    bit          m_ff = 0;
    bit          m_ovr = 0;
    bit          m_active = 0;
    int          exp_idx = 0;
    int          hs_cnt = 0;
    int          ready_mode = 0;
    int          hold_cnt = 0;
    int          cnt3 = 0;
    int          duty3 = -1;
    int          duty0 = -1;
    int          first_idx = -1;
    bit          chk_en = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic void model_write(input logic [15:0] a,
                                        input logic [15:0] d,
                                        input bit busy);
        int bank, off;
        bank = int'(a[15:14]);
        off  = int'(a[7:0]);
        if (bank == 0) begin
            if (off == 0) begin
                if (d[2]) m_ovr = 0;
                m_ff = d[1];
                if (d[0]) begin
                    if (busy) m_ovr = 1;
                    else begin
                        m_active = 1;
                        exp_idx  = 0;
                    end
                end
            end else if (off == 2) begin
                m_step = d[12:0];
            end
        end else if (busy) begin
            m_ovr = 1;
        end else if (off < N) begin
            case (bank)
                1: m_cyc[off]  = d[12:0];
                2: m_duty[off] = d[12:0];
                default: m_ph[off] = d[12:0];
            endcase
        end
    endfunction

    function automatic logic [15:0] exp_read(input logic [15:0] a);
        int bank, off;
        bank = int'(a[15:14]);
        off  = int'(a[7:0]);
        exp_read = '0;
        if (bank == 0) begin
            if (off == 1) exp_read = {8'h02, 6'b0, m_ovr, m_active};
            else if (off == 2) exp_read = {3'b0, m_step};
        end else begin
`ifdef AUTD_CPU_READBACK_EN
            if (off < N && !m_active) begin
                case (bank)
                    1: exp_read = {3'b0, m_cyc[off]};
                    2: exp_read = {3'b0, m_duty[off]};
                    default: exp_read = {3'b0, m_ph[off]};
                endcase
            end
`endif
        end
    endfunction

    task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
        bit busy_now;
        @(posedge clk);
        #1;
        addr = a; tb_dat = d; tb_drv = 1; cs_n = 0; we_n = 0;
        @(posedge clk);
        busy_now = m_active;
        #1;
        model_write(a, d, busy_now);
        @(posedge clk);
        #1;
        we_n = 1; cs_n = 1; tb_drv = 0;
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [15:0] d);
        @(posedge clk);
        #1;
        addr = a; cs_n = 0; rd_n = 0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        d = cpu_data;
        @(posedge clk);
        #1;
        cs_n = 1; rd_n = 1;
    endtask

    task automatic check_read(input string name, input logic [15:0] a);
        logic [15:0] d;
        bus_read(a, d);
        check(name, d, exp_read(a));
    endtask

    task automatic check_lit(input string name, input logic [15:0] a,
                             input logic [15:0] lit);
        logic [15:0] d;
        bus_read(a, d);
        check(name, d, lit);
    endtask

    task automatic bus_released();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("bus_hiz", cpu_data, 16'hFFFF);
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (m_active && n < budget) begin
            @(posedge clk);
            n++;
        end
        check("stream_in_budget", m_active, 0);
        repeat (2) @(posedge clk);
        #1;
        check("busy_low_after", busy_o, 0);
    endtask

    // Consumer ready pattern
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0: out_ready = 1'b1;
            1: out_ready = 1'($urandom_range(0, 1));
            2: out_ready = 1'b0;
            default: begin
                if (out_valid && out_idx == 8'd3 && hold_cnt < 10) begin
                    out_ready = 1'b0;
                    hold_cnt++;
                end else begin
                    out_ready = 1'b1;
                end
            end
        endcase
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (rst_n && chk_en) begin
            check("step", step_o, m_step);
            check("force_fan", force_fan_o, m_ff);
            if (m_active) begin
                if (out_valid) begin
                    if (first_idx < 0) first_idx = int'(out_idx);
                    check("out_idx", out_idx, exp_idx);
                    check("out_cycle", out_cycle, m_cyc[exp_idx]);
                    check("out_duty", out_duty, m_duty[exp_idx]);
                    check("out_phase", out_phase, m_ph[exp_idx]);
                    if (out_idx == 8'd3) begin
                        cnt3++;
                        duty3 = int'(out_duty);
                    end
                    if (out_ready) begin
                        if (exp_idx == 0) duty0 = int'(out_duty);
                        hs_cnt++;
                        if (exp_idx == N - 1) m_active = 0;
                        else exp_idx++;
                    end
                end
            end else begin
                check("valid_idle", out_valid, 0);
            end
        end
    end

    initial begin
        logic [15:0] a, d;
        int n;
        for (int i = 0; i < N; i++) begin
            m_cyc[i] = '0; m_duty[i] = '0; m_ph[i] = '0;
        end
        rst_n = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_step", step_o, 0);
        check("rst_fan", force_fan_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_valid", out_valid, 0);
        check("rst_idx", out_idx, 0);
        check("rst_cycle", out_cycle, 0);
        check("rst_bus", cpu_data, 16'hFFFF);
        rst_n = 1;
        chk_en = 1;

        check_lit("status_rst", 16'h0001, 16'h0200);
        check_lit("step_rst", 16'h0002, 16'h0000);
        bus_released();
        bus_write(16'h0002, 16'hFFFF);
        #1;
        check("step_trunc", step_o, 13'h1FFF);
        check_lit("step_rb", 16'h0002, 16'h1FFF);
        bus_released();
        bus_write(16'h0000, 16'h0002);
        check("fan_on", force_fan_o, 1);
        bus_write(16'h0000, 16'h0000);
        check_read("other_reg", 16'h0007);

        for (int i = 0; i < N; i++) begin
            bus_write(16'h4000 | 16'(i), 16'd5000);
            bus_write(16'h8000 | 16'(i), 16'(i));
            bus_write(16'hC000 | 16'(i), 16'd2500);
        end
`ifdef AUTD_CPU_READBACK_EN
        check_lit("phase5_rb", 16'hC005, 16'd2500);
`else
        check_lit("phase5_rb", 16'hC005, 16'd0);
`endif

        ready_mode = 0;
        hs_cnt = 0;
        bus_write(16'h0000, 16'h0001);
        wait_done(2000);
        check("hs_full", hs_cnt, N);

        ready_mode = 3;
        hold_cnt = 0;
        cnt3 = 0;
        hs_cnt = 0;
        bus_write(16'h0000, 16'h0001);
        wait_done(2000);
        check("stall_cycles", cnt3, 11);
        check("stall_duty", duty3, 3);
        check("hs_stall", hs_cnt, N);

        ready_mode = 2;
        hs_cnt = 0;
        duty0 = -1;
        bus_write(16'h0000, 16'h0001);
        repeat (4) @(posedge clk);
        bus_write(16'h8000, 16'h0007);
        bus_write(16'h0000, 16'h0001);
        check_lit("ovr_set", 16'h0001, 16'h0203);
        bus_write(16'h0002, 16'h0ABC);
        check_read("step_busy", 16'h0002);
        bus_write(16'h0000, 16'h0004);
        check_lit("ovr_clr", 16'h0001, 16'h0201);
        bus_write(16'h0000, 16'h0005);
        check_lit("ovr_clr_commit", 16'h0001, 16'h0203);
        bus_write(16'h0000, 16'h0004);
        ready_mode = 0;
        wait_done(2000);
        check("duty0_kept", duty0, 0);
        check_lit("status_idle", 16'h0001, 16'h0200);

        bus_write(16'h4000 | 16'd249, 16'd123);
        check_lit("oob_no_ovr", 16'h0001, 16'h0200);

        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 250; k++) begin
                if ($urandom_range(0, 9) == 0) begin
                    a = 16'h0002;
                end else begin
                    a = {2'($urandom_range(1, 3)), 6'b0, 8'($urandom)};
                end
                d = 16'($urandom);
                bus_write(a, d);
            end
            for (int k = 0; k < 20; k++) begin
                if ($urandom_range(0, 3) == 0) begin
                    a = {8'h00, 8'($urandom_range(1, 255))};
                end else begin
                    a = {2'($urandom_range(1, 3)), 6'b0, 8'($urandom)};
                end
                check_read("rand_read", a);
            end
            ready_mode = 1;
            hs_cnt = 0;
            bus_write(16'h0000, 16'h0001);
            wait_done(4000);
            check("hs_rand", hs_cnt, N);
        end

        ready_mode = 0;
        hs_cnt = 0;
        bus_write(16'h0000, 16'h0001);
        n = 0;
        while (!(out_valid && out_idx == 8'd100) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("reach_idx100", n < 2000, 1);
        #2;
        rst_n = 0;
        m_step = '0; m_ff = 0; m_ovr = 0; m_active = 0;
        #1;
        check("abort_valid", out_valid, 0);
        check("abort_busy", busy_o, 0);
        check("abort_idx", out_idx, 0);
        check("abort_duty", out_duty, 0);
        check("abort_step", step_o, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1;
        hs_cnt = 0;
        first_idx = -1;
        bus_write(16'h0000, 16'h0001);
        wait_done(2000);
        check("restart_idx0", first_idx, 0);
        check("hs_restart", hs_cnt, N);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
